// File: rtl/resonator_dds_cmix_round.sv
// Post-multiply stage of the resonator DDS complex mixer.
// Combines the four partial products of (a+jb)(c+jd) into I/Q, rounds
// half-up, saturates to OUT_W bits and hands the result downstream on a
// valid/ready port. A single global stall freezes the multipliers, the
// validity shift register and both post-multiply stages together.
module resonator_dds_cmix_round #(
    parameter int MUL_LATENCY = 3,
    parameter int SHIFT       = 15,
    parameter int OUT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             mul_ce,
    input  logic [31:0]      p_ac,
    input  logic [31:0]      p_bd,
    input  logic [31:0]      p_ad,
    input  logic [31:0]      p_bc,
    output logic [OUT_W-1:0] m_i,
    output logic [OUT_W-1:0] m_q,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             sat_clr,
    output logic [15:0]      sat_count
);

    localparam logic signed [33:0] RND_C     = 34'sh1 <<< (SHIFT - 1);
    localparam logic signed [33:0] SAT_MAX_C = (34'sh1 <<< (OUT_W - 1)) - 34'sh1;
    localparam logic signed [33:0] SAT_MIN_C = -(34'sh1 <<< (OUT_W - 1));

    // Half-up rounding followed by arithmetic shift, done at 34 bits so the
    // rounding constant can never overflow the 33-bit sum.
    function automatic logic signed [33:0] round_shift(input logic signed [32:0] s);
        logic signed [33:0] r;
        r = $signed({s[32], s}) + RND_C;
        return r >>> SHIFT;
    endfunction

    // True when the shifted value lies outside the output range.
    function automatic logic is_sat(input logic signed [33:0] t);
        return (t > SAT_MAX_C) || (t < SAT_MIN_C);
    endfunction

    // Clamp the shifted value into the signed output range.
    function automatic logic [OUT_W-1:0] sat_fn(input logic signed [33:0] t);
        logic signed [33:0] c;
        if (t > SAT_MAX_C) begin
            c = SAT_MAX_C;
        end else if (t < SAT_MIN_C) begin
            c = SAT_MIN_C;
        end else begin
            c = t;
        end
        return c[OUT_W-1:0];
    endfunction

    logic [MUL_LATENCY-1:0] vld_q, vld_d;
    logic signed [32:0]     si_q, si_d, sq_q, sq_d;
    logic                   v1_q, v1_d;
    logic [OUT_W-1:0]       m_i_q, m_i_d, m_q_q, m_q_d;
    logic                   m_valid_q, m_valid_d;
    logic [15:0]            sat_count_q, sat_count_d;
    logic                   stall_s, mul_ce_s, accept_s, sat_hit_s;
    logic signed [33:0]     ti_s, tq_s;

    // Global enable: only a held, unaccepted output sample stalls the chain;
    // while in reset the multipliers keep running so stale operands flush.
    always_comb begin
        stall_s = m_valid_q & ~m_ready;
        if (reset) begin
            mul_ce_s = ~stall_s;
        end else begin
            mul_ce_s = 1'b1;
        end
        accept_s = s_valid & mul_ce_s;
    end

    // Next-state for validity tracking, the S1 sums and the S2 output stage.
    always_comb begin
        vld_d[0] = accept_s;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        si_d      = $signed({p_ac[31], p_ac}) - $signed({p_bd[31], p_bd});
        sq_d      = $signed({p_ad[31], p_ad}) + $signed({p_bc[31], p_bc});
        v1_d      = vld_q[MUL_LATENCY-1];
        ti_s      = round_shift(si_q);
        tq_s      = round_shift(sq_q);
        m_i_d     = sat_fn(ti_s);
        m_q_d     = sat_fn(tq_s);
        m_valid_d = v1_q;
        sat_hit_s = v1_q & (is_sat(ti_s) | is_sat(tq_s));
    end

    // Saturation counter: clear wins over an increment, and it sticks at max.
    always_comb begin
        if (sat_clr) begin
            sat_count_d = 16'h0000;
        end else if (mul_ce_s && sat_hit_s && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'h0001;
        end else begin
            sat_count_d = sat_count_q;
        end
    end

    // Pipeline registers: all stages advance together on an enabled edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q       <= '0;
            si_q        <= 33'sh0;
            sq_q        <= 33'sh0;
            v1_q        <= 1'b0;
            m_i_q       <= '0;
            m_q_q       <= '0;
            m_valid_q   <= 1'b0;
            sat_count_q <= 16'h0000;
        end else begin
            sat_count_q <= sat_count_d;
            if (mul_ce_s) begin
                vld_q     <= vld_d;
                si_q      <= si_d;
                sq_q      <= sq_d;
                v1_q      <= v1_d;
                m_i_q     <= m_i_d;
                m_q_q     <= m_q_d;
                m_valid_q <= m_valid_d;
            end
        end
    end

    assign mul_ce    = mul_ce_s;
    assign s_ready   = mul_ce_s;
    assign m_i       = m_i_q;
    assign m_q       = m_q_q;
    assign m_valid   = m_valid_q;
    assign sat_count = sat_count_q;

endmodule
